wordle_game_ctrl: RTL

WORDLE_GAME_CTRL -- requirements
Module: wordle_game_ctrl

---
 rtl/wordle_game_ctrl.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/wordle_game_ctrl.sv
// -----------------------------------------------------------------------------
// wordle_game_ctrl
//
// Purpose: game controller for a Wordle-style word puzzle. Collects letters
// for the current row from a key interface, scores a submitted row against a
// secret word latched at game start (exact matches first, then left-to-right
// "present" matching that never credits a target letter twice), and tracks
// guesses until the word is found or the guess budget runs out.
//
// Ports:
//   clk          - single clock, rising edge
//   clr          - asynchronous active-high reset
//   start        - pulse: begin a game (IDLE) or leave WIN/LOSE back to IDLE
//   target_word  - secret word, letter i at [LW*i +: LW], latched on start
//   key_valid    - key_letter holds a letter this cycle
//   key_letter   - letter code (0..25 legal)
//   key_del      - delete the last entered letter
//   key_submit   - submit the current row
//   row_cells    - current row, cell i = {color[1:0], letter} zero-padded to 7b
//   cursor       - number of letters entered in the current row
//   guess_count  - number of completed (scored) guesses
//   state        - IDLE=0 EDIT=1 SCORE_G=2 SCORE_Y=3 CHECK=4 WIN=5 LOSE=6
//   score_valid  - one-cycle pulse when row_cells holds the final colors
//   reject       - one-cycle pulse after an incomplete row was submitted
// -----------------------------------------------------------------------------
module wordle_game_ctrl #(
  parameter int WORD_LEN    = 5,
  parameter int MAX_GUESSES = 6,
  parameter int LW          = 5
) (
  input  logic                               clk,
  input  logic                               clr,
  input  logic                               start,
  input  logic [WORD_LEN*LW-1:0]             target_word,
  input  logic                               key_valid,
  input  logic [LW-1:0]                      key_letter,
  input  logic                               key_del,
  input  logic                               key_submit,
  output logic [WORD_LEN*7-1:0]              row_cells,
  output logic [$clog2(WORD_LEN+1)-1:0]      cursor,
  output logic [3:0]                         guess_count,
  output logic [2:0]                         state,
  output logic                               score_valid,
  output logic                               reject
);

  localparam int CW = $clog2(WORD_LEN+1);

  localparam logic [LW-1:0] EMPTY      = LW'(26);
  localparam logic [LW-1:0] MAX_LETTER = LW'(25);

  localparam logic [1:0] C_NONE    = 2'b00;
  localparam logic [1:0] C_ABSENT  = 2'b01;
  localparam logic [1:0] C_PRESENT = 2'b10;
  localparam logic [1:0] C_CORRECT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EDIT    = 3'd1,
    S_SCORE_G = 3'd2,
    S_SCORE_Y = 3'd3,
    S_CHECK   = 3'd4,
    S_WIN     = 3'd5,
    S_LOSE    = 3'd6
  } state_t;

  state_t                 state_q,       state_d;
  logic [LW-1:0]          letter_q [WORD_LEN];
  logic [LW-1:0]          letter_d [WORD_LEN];
  logic [1:0]             color_q  [WORD_LEN];
  logic [1:0]             color_d  [WORD_LEN];
  logic [WORD_LEN*LW-1:0] target_q,      target_d;
  logic [WORD_LEN-1:0]    used_q,        used_d;
  logic [CW-1:0]          j_q,           j_d;
  logic [CW-1:0]          cursor_q,      cursor_d;
  logic [3:0]             guess_q,       guess_d;
  logic                   score_valid_q, score_valid_d;
  logic                   reject_q,      reject_d;

  // Per-position views of the latched target and row status
  logic [LW-1:0]       tgt [WORD_LEN];
  logic [WORD_LEN-1:0] green_hit;
  logic [WORD_LEN-1:0] cell_correct;

  generate
    for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_cell
      assign tgt[gi]          = target_q[LW*gi +: LW];
      assign green_hit[gi]    = (letter_q[gi] == tgt[gi]);
      assign cell_correct[gi] = (color_q[gi] == C_CORRECT);
      if (LW + 2 < 7) begin : g_pad
        assign row_cells[7*gi +: 7] = {{(5-LW){1'b0}}, color_q[gi], letter_q[gi]};
      end else begin : g_nopad
        assign row_cells[7*gi +: 7] = {color_q[gi], letter_q[gi]};
      end
    end
  endgenerate

  // Yellow pass helper: letter/color of cell j and the lowest unused target
  // position holding the same letter (one-hot, so it can be OR-ed into used).
  logic [LW-1:0]       guess_j;
  logic [1:0]          color_j;
  logic                match_found;
  logic [WORD_LEN-1:0] match_onehot;

  always_comb begin
    guess_j      = '0;
    color_j      = C_NONE;
    match_found  = 1'b0;
    match_onehot = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (CW'(i) == j_q) begin
        guess_j = letter_q[i];
        color_j = color_q[i];
      end
    end
    for (int k = 0; k < WORD_LEN; k++) begin
      if (!match_found && !used_q[k] && (tgt[k] == guess_j)) begin
        match_onehot[k] = 1'b1;
        match_found     = 1'b1;
      end
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d       = state_q;
    letter_d      = letter_q;
    color_d       = color_q;
    target_d      = target_q;
    used_d        = used_q;
    j_d           = j_q;
    cursor_d      = cursor_q;
    guess_d       = guess_q;
    score_valid_d = 1'b0;
    reject_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d = target_word;
          for (int i = 0; i < WORD_LEN; i++) begin
            letter_d[i] = EMPTY;
            color_d[i]  = C_NONE;
          end
          used_d   = '0;
          cursor_d = '0;
          guess_d  = '0;
          state_d  = S_EDIT;
        end
      end

      S_EDIT: begin
        if (key_submit) begin
          if (cursor_q == CW'(WORD_LEN)) begin
            state_d = S_SCORE_G;
          end else begin
            reject_d = 1'b1;
          end
        end else if (key_del) begin
          if (cursor_q != '0) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if (CW'(i) == cursor_q - CW'(1)) begin
                letter_d[i] = EMPTY;
                color_d[i]  = C_NONE;
              end
            end
            cursor_d = cursor_q - CW'(1);
          end
        end else if (key_valid) begin
          if ((cursor_q < CW'(WORD_LEN)) && (key_letter <= MAX_LETTER)) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if (CW'(i) == cursor_q) begin
                letter_d[i] = key_letter;
                color_d[i]  = C_NONE;
              end
            end
            cursor_d = cursor_q + CW'(1);
          end
        end
      end

      S_SCORE_G: begin
        // Exact matches claim their target letter before any yellow search
        for (int i = 0; i < WORD_LEN; i++) begin
          if (green_hit[i]) begin
            color_d[i] = C_CORRECT;
          end
        end
        used_d  = green_hit;
        j_d     = '0;
        state_d = S_SCORE_Y;
      end

      S_SCORE_Y: begin
        if (color_j != C_CORRECT) begin
          for (int i = 0; i < WORD_LEN; i++) begin
            if (CW'(i) == j_q) begin
              color_d[i] = match_found ? C_PRESENT : C_ABSENT;
            end
          end
          used_d = used_q | match_onehot;
        end
        if (j_q == CW'(WORD_LEN-1)) begin
          guess_d       = guess_q + 4'd1;
          score_valid_d = 1'b1;
          state_d       = S_CHECK;
        end else begin
          j_d = j_q + CW'(1);
        end
      end

      S_CHECK: begin
        if (&cell_correct) begin
          state_d = S_WIN;
        end else if (guess_q == 4'(MAX_GUESSES)) begin
          state_d = S_LOSE;
        end else begin
          for (int i = 0; i < WORD_LEN; i++) begin
            letter_d[i] = EMPTY;
            color_d[i]  = C_NONE;
          end
          used_d   = '0;
          cursor_d = '0;
          state_d  = S_EDIT;
        end
      end

      S_WIN, S_LOSE: begin
        // Scored row stays visible until the player acknowledges with start
        if (start) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      for (int i = 0; i < WORD_LEN; i++) begin
        letter_q[i] <= EMPTY;
        color_q[i]  <= C_NONE;
      end
      target_q      <= '0;
      used_q        <= '0;
      j_q           <= '0;
      cursor_q      <= '0;
      guess_q       <= '0;
      score_valid_q <= 1'b0;
      reject_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      letter_q      <= letter_d;
      color_q       <= color_d;
      target_q      <= target_d;
      used_q        <= used_d;
      j_q           <= j_d;
      cursor_q      <= cursor_d;
      guess_q       <= guess_d;
      score_valid_q <= score_valid_d;
      reject_q      <= reject_d;
    end
  end

  assign cursor      = cursor_q;
  assign guess_count = guess_q;
  assign state       = 3'(state_q);
  assign score_valid = score_valid_q;
  assign reject      = reject_q;

endmodule
